// File: rtl/axi_lite_reg_bank.sv
// axi_lite_reg_bank: AXI-Lite slave exposing a bank of byte-writable control/status registers
module axi_lite_reg_bank #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          aw_addr,
  input  logic                           aw_valid,
  output logic                           aw_ready,
  input  logic [DATA_WIDTH-1:0]          w_data,
  input  logic [DATA_WIDTH/8-1:0]        w_strb,
  input  logic                           w_valid,
  output logic                           w_ready,
  output logic [1:0]                     b_resp,
  output logic                           b_valid,
  input  logic                           b_ready,
  input  logic [ADDR_WIDTH-1:0]          ar_addr,
  input  logic                           ar_valid,
  output logic                           ar_ready,
  output logic [DATA_WIDTH-1:0]          r_data,
  output logic [1:0]                     r_resp,
  output logic                           r_valid,
  input  logic                           r_ready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_hw_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int LSB = $clog2(SW);
  localparam int WW = ADDR_WIDTH - LSB;
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  aw_held, w_held, aw_oor_q;
  logic [IW-1:0]         aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q, wmask, wnew;
  logic [SW-1:0]         w_strb_q;
  logic [WW-1:0]         aw_word, ar_word;
  logic [IW-1:0]         ar_idx;
  logic                  aw_oor, ar_oor, commit, wr_en;
  logic                  unused_lsb;
  assign aw_word = aw_addr[ADDR_WIDTH-1:LSB];
  assign ar_word = ar_addr[ADDR_WIDTH-1:LSB];
  assign aw_oor = aw_word >= WW'(NUM_REGS);
  assign ar_oor = ar_word >= WW'(NUM_REGS);
  assign ar_idx = ar_word[IW-1:0];
  assign unused_lsb = ^{aw_addr[LSB-1:0], ar_addr[LSB-1:0]};
  // readies are forced low while reset is asserted so the port is fully quiet
  assign aw_ready = rst_n && !aw_held && !b_valid;
  assign w_ready = rst_n && !w_held && !b_valid;
  assign ar_ready = rst_n && !r_valid;
  assign commit = aw_held && w_held;
  assign wr_en = commit && !aw_oor_q && !RO_MASK[aw_idx_q] && |w_strb_q;
  always_comb begin
    wmask = '0;
    for (int k = 0; k < SW; k++) wmask[8*k +: 8] = {8{w_strb_q[k]}};
  end
  assign wnew = (regs[aw_idx_q] & ~wmask) | (w_data_q & wmask);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_oor_q <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      b_valid  <= 1'b0;
      b_resp   <= 2'b00;
      wr_pulse <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_resp   <= 2'b00;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      wr_pulse <= '0;
      if (aw_valid && aw_ready) begin
        aw_held  <= 1'b1;
        aw_idx_q <= aw_word[IW-1:0];
        aw_oor_q <= aw_oor;
      end
      if (w_valid && w_ready) begin
        w_held   <= 1'b1;
        w_data_q <= w_data;
        w_strb_q <= w_strb;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        b_valid <= 1'b1;
        b_resp  <= aw_oor_q ? 2'b11 : (RO_MASK[aw_idx_q] ? 2'b10 : 2'b00);
      end else if (b_valid && b_ready) begin
        b_valid <= 1'b0;
      end
      if (wr_en) begin
        regs[aw_idx_q]     <= wnew;
        wr_pulse[aw_idx_q] <= 1'b1;
      end
      // the read samples regs before this edge's commit, so it sees the old value
      if (ar_valid && ar_ready) begin
        r_valid <= 1'b1;
        r_resp  <= ar_oor ? 2'b11 : 2'b00;
        r_data  <= ar_oor ? '0 : (RO_MASK[ar_idx] ? reg_hw_in[ar_idx*DATA_WIDTH +: DATA_WIDTH] : regs[ar_idx]);
      end else if (r_valid && r_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
  end
endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// tb_axi_lite_reg_bank: vector table plus hand sequences, checked through response scoreboards
module tb_axi_lite_reg_bank;
  localparam int NR = 8;
  localparam logic [7:0] RO = 8'h10;
  localparam logic [31:0] RV = 32'hA5A5_0001;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] aw_addr = '0, w_data = '0, ar_addr = '0, r_data;
  logic [3:0] w_strb = '0;
  logic aw_valid = 1'b0, w_valid = 1'b0, ar_valid = 1'b0, b_ready = 1'b1, r_ready = 1'b1;
  logic aw_ready, w_ready, ar_ready, b_valid, r_valid;
  logic [1:0] b_resp, r_resp;
  logic [255:0] reg_q, reg_hw_in;
  logic [7:0] wr_pulse;
  always #5 clk = ~clk;
  axi_lite_reg_bank #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VAL(RV)) dut (
    .clk(clk), .rst_n(rst_n),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .reg_q(reg_q), .reg_hw_in(reg_hw_in), .wr_pulse(wr_pulse)
  );
  typedef struct { logic [1:0] resp; logic [7:0] pulse; logic [255:0] q; } bexp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; logic [1:0] resp; logic [31:0] exp; logic [7:0] pulse; } vec_t;
  bexp_t bq [$];
  rexp_t rq [$];
  bexp_t be;
  rexp_t re;
  logic [31:0] mq [NR];
  logic bv_prev = 1'b0;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [255:0] mq_flat();
    logic [255:0] f;
    for (int i = 0; i < NR; i++) f[i*32 +: 32] = mq[i];
    return f;
  endfunction
  function automatic logic rdy(input int ch);
    return ch == 0 ? aw_ready : (ch == 1 ? w_ready : ar_ready);
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      bv_prev = 1'b0;
    end else begin
      chk("wr_pulse", 256'(wr_pulse), 256'((b_valid && !bv_prev && bq.size() > 0) ? bq[0].pulse : 8'h00));
      bv_prev = b_valid;
      if (b_valid && b_ready) begin
        if (bq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_unexpected: got b_resp %0h expected no response", b_resp);
        end else begin
          be = bq.pop_front();
          chk("b_resp", 256'(b_resp), 256'(be.resp));
          chk("reg_q", reg_q, be.q);
        end
      end
      if (r_valid && r_ready) begin
        if (rq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL r_unexpected: got r_data %0h expected no response", r_data);
        end else begin
          re = rq.pop_front();
          chk("r_data", 256'(r_data), 256'(re.data));
          chk("r_resp", 256'(r_resp), 256'(re.resp));
        end
      end
    end
  end
  task automatic hs(input int ch);
    int n = 0;
    @(negedge clk);
    while (!rdy(ch) && n < 50) begin @(negedge clk); n++; end
    if (!rdy(ch)) begin
      n_cmp++; n_bad++;
      $display("FAIL handshake_timeout: channel %0d got ready 0 expected 1", ch);
    end
    @(posedge clk); #1;
    if (ch == 0) aw_valid = 1'b0;
    else if (ch == 1) w_valid = 1'b0;
    else ar_valid = 1'b0;
  endtask
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int order);
    aw_addr = a; w_data = d; w_strb = s;
    if (order == 0) begin
      aw_valid = 1'b1; w_valid = 1'b1;
      fork hs(0); hs(1); join
    end else if (order == 1) begin
      aw_valid = 1'b1; hs(0);
      repeat (2) @(posedge clk);
      #1; w_valid = 1'b1; hs(1);
    end else begin
      w_valid = 1'b1; hs(1);
      @(posedge clk); #1;
      aw_valid = 1'b1; hs(0);
    end
  endtask
  task automatic drain();
    int n = 0;
    while ((bq.size() > 0 || rq.size() > 0) && n < 50) begin @(posedge clk); n++; end
    if (bq.size() > 0 || rq.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", bq.size() + rq.size());
      bq.delete(); rq.delete();
    end
    #1;
  endtask
  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    rq.push_back('{d, r});
    ar_addr = a; ar_valid = 1'b1; hs(2);
    drain();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    vec_t tv [19];
    logic [31:0] old;
    tv[0]  = '{1'b0, 32'h0C, 32'h0, 4'h0, 2'b00, 32'hA5A50001, 8'h00};
    tv[1]  = '{1'b1, 32'h04, 32'h11223344, 4'hF, 2'b00, 32'h11223344, 8'h02};
    tv[2]  = '{1'b1, 32'h04, 32'hAABBCCDD, 4'h5, 2'b00, 32'h11BB33DD, 8'h02};
    tv[3]  = '{1'b0, 32'h04, 32'h0, 4'h0, 2'b00, 32'h11BB33DD, 8'h00};
    tv[4]  = '{1'b1, 32'h10, 32'h12345678, 4'hF, 2'b10, 32'h0, 8'h00};
    tv[5]  = '{1'b0, 32'h10, 32'h0, 4'h0, 2'b00, 32'h0000CAFE, 8'h00};
    tv[6]  = '{1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 2'b11, 32'h0, 8'h00};
    tv[7]  = '{1'b0, 32'h20, 32'h0, 4'h0, 2'b11, 32'h0, 8'h00};
    tv[8]  = '{1'b1, 32'h1F, 32'h01020304, 4'hF, 2'b00, 32'h01020304, 8'h80};
    tv[9]  = '{1'b0, 32'h1C, 32'h0, 4'h0, 2'b00, 32'h01020304, 8'h00};
    tv[10] = '{1'b1, 32'h1C, 32'h99999999, 4'h0, 2'b00, 32'h01020304, 8'h00};
    tv[11] = '{1'b0, 32'h1E, 32'h0, 4'h0, 2'b00, 32'h01020304, 8'h00};
    tv[12] = '{1'b1, 32'h00, 32'h000000EE, 4'h1, 2'b00, 32'hA5A500EE, 8'h01};
    tv[13] = '{1'b0, 32'h00, 32'h0, 4'h0, 2'b00, 32'hA5A500EE, 8'h00};
    tv[14] = '{1'b0, 32'h40, 32'h0, 4'h0, 2'b11, 32'h0, 8'h00};
    tv[15] = '{1'b1, 32'h14, 32'hCAFED00D, 4'h1, 2'b00, 32'hA5A5000D, 8'h20};
    tv[16] = '{1'b0, 32'h14, 32'h0, 4'h0, 2'b00, 32'hA5A5000D, 8'h00};
    tv[17] = '{1'b1, 32'h0C, 32'h00FF0000, 4'h4, 2'b00, 32'hA5FF0001, 8'h08};
    tv[18] = '{1'b0, 32'h0C, 32'h0, 4'h0, 2'b00, 32'hA5FF0001, 8'h00};
    for (int i = 0; i < NR; i++) begin
      reg_hw_in[i*32 +: 32] = (i == 4) ? 32'h0000CAFE : (32'hBAD00000 | 32'(i));
      mq[i] = RO[i] ? 32'h0 : RV;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_aw_ready", 256'(aw_ready), 256'(0));
    chk("rst_w_ready", 256'(w_ready), 256'(0));
    chk("rst_ar_ready", 256'(ar_ready), 256'(0));
    chk("rst_b_valid", 256'(b_valid), 256'(0));
    chk("rst_r_valid", 256'(r_valid), 256'(0));
    chk("rst_r_data", 256'(r_data), 256'(0));
    chk("rst_wr_pulse", 256'(wr_pulse), 256'(0));
    chk("rst_reg_q", reg_q, mq_flat());
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_aw_ready", 256'(aw_ready), 256'(1));
    chk("post_rst_ar_ready", 256'(ar_ready), 256'(1));
    for (int i = 0; i < 19; i++) begin
      if (tv[i].wr) begin
        if (tv[i].resp == 2'b00) mq[tv[i].addr[4:2]] = tv[i].exp;
        bq.push_back('{tv[i].resp, tv[i].pulse, mq_flat()});
        do_write(tv[i].addr, tv[i].data, tv[i].strb, i % 3);
        drain();
      end else begin
        do_read(tv[i].addr, tv[i].exp, tv[i].resp);
      end
    end
    // AW alone, W three cycles later, then b_ready stalled
    b_ready = 1'b0;
    mq[2] = 32'hDEADBEEF;
    bq.push_back('{2'b00, 8'h04, mq_flat()});
    chk("seqA_aw_ready", 256'(aw_ready), 256'(1));
    aw_addr = 32'h08; aw_valid = 1'b1;
    @(posedge clk); #1;
    aw_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("seqA_no_b_yet", 256'(b_valid), 256'(0));
      chk("seqA_aw_ready_held", 256'(aw_ready), 256'(0));
      chk("seqA_w_ready_open", 256'(w_ready), 256'(1));
      @(posedge clk); #1;
    end
    w_data = 32'hDEADBEEF; w_strb = 4'hF; w_valid = 1'b1;
    @(posedge clk); #1;
    w_valid = 1'b0;
    @(negedge clk);
    chk("seqA_b_latency", 256'(b_valid), 256'(0));
    @(posedge clk); #1;
    chk("seqA_b_valid", 256'(b_valid), 256'(1));
    chk("seqA_reg2", 256'(reg_q[95:64]), 256'(32'hDEADBEEF));
    repeat (5) begin
      @(negedge clk);
      chk("stall_aw_ready", 256'(aw_ready), 256'(0));
      chk("stall_w_ready", 256'(w_ready), 256'(0));
      chk("stall_b_valid", 256'(b_valid), 256'(1));
      chk("stall_b_resp", 256'(b_resp), 256'(0));
    end
    @(posedge clk); #1;
    b_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_b_valid", 256'(b_valid), 256'(0));
    chk("stall_release_aw_ready", 256'(aw_ready), 256'(1));
    drain();
    do_read(32'h08, 32'hDEADBEEF, 2'b00);
    // read sampled on the same edge as a commit to the same register
    old = mq[6];
    mq[6] = 32'h13572468;
    bq.push_back('{2'b00, 8'h40, mq_flat()});
    rq.push_back('{old, 2'b00});
    aw_addr = 32'h18; w_data = 32'h13572468; w_strb = 4'hF;
    aw_valid = 1'b1; w_valid = 1'b1;
    @(posedge clk); #1;
    aw_valid = 1'b0; w_valid = 1'b0;
    ar_addr = 32'h18; ar_valid = 1'b1;
    @(posedge clk); #1;
    ar_valid = 1'b0;
    drain();
    do_read(32'h18, 32'h13572468, 2'b00);
    // reset while an AW is held; the orphaned AW must never produce a response
    aw_addr = 32'h00; aw_valid = 1'b1;
    @(posedge clk); #1;
    aw_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) mq[i] = RO[i] ? 32'h0 : RV;
    chk("rst2_aw_ready", 256'(aw_ready), 256'(0));
    chk("rst2_w_ready", 256'(w_ready), 256'(0));
    chk("rst2_ar_ready", 256'(ar_ready), 256'(0));
    chk("rst2_b_valid", 256'(b_valid), 256'(0));
    chk("rst2_r_valid", 256'(r_valid), 256'(0));
    chk("rst2_r_data", 256'(r_data), 256'(0));
    chk("rst2_b_resp", 256'(b_resp), 256'(0));
    chk("rst2_reg_q", reg_q, mq_flat());
    rst_n = 1'b1;
    w_data = 32'h0BADF00D; w_strb = 4'hF; w_valid = 1'b1;
    hs(1);
    repeat (4) begin
      @(negedge clk);
      chk("rst2_no_b_valid", 256'(b_valid), 256'(0));
    end
    mq[1] = 32'h0BADF00D;
    bq.push_back('{2'b00, 8'h02, mq_flat()});
    aw_addr = 32'h04; aw_valid = 1'b1;
    hs(0);
    drain();
    do_read(32'h04, 32'h0BADF00D, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_lite_reg_bank.md
Name: axi_lite_reg_bank

Overview:
- Parametrised AXI-Lite slave that exposes NUM_REGS data-width registers to the fabric and to local hardware.
- Accepts AW and W independently, with byte-strobe writes.
- Supports per-register read-only mapping, with reads served from hardware inputs.
- Returns SLVERR/DECERR responses.
- Sits behind the AXI-Lite interconnect as the standard control/status block for peripherals.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width; must be 32 or 64.
- NUM_REGS, 8, register count; must be at least 1.
- RO_MASK, {NUM_REGS{1'b0}}, bit i=1 makes register i read-only (value sourced from reg_hw_in).
- RESET_VAL, 0, reset value of all writable registers.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- aw_addr  in  ADDR_WIDTH  write address
- aw_valid  in  1  write address valid
- aw_ready  out  1  write address ready
- w_data  in  DATA_WIDTH  write data
- w_strb  in  DATA_WIDTH/8  byte enables
- w_valid  in  1  write data valid
- w_ready  out  1  write data ready
- b_resp  out  2  write response
- b_valid  out  1  write response valid
- b_ready  in  1  write response ready
- ar_addr  in  ADDR_WIDTH  read address
- ar_valid  in  1  read address valid
- ar_ready  out  1  read address ready
- r_data  out  DATA_WIDTH  read data
- r_resp  out  2  read response
- r_valid  out  1  read data valid
- r_ready  in  1  read data ready
- reg_q  out  NUM_REGS*DATA_WIDTH  writable register contents; slice i = register i
- reg_hw_in  in  NUM_REGS*DATA_WIDTH  hardware values for read-only registers
- wr_pulse  out  NUM_REGS  one-cycle strobe when register i is written

Behaviour:
- Reset (rst_n=0 at rising edge):
  - All handshake outputs 0; b_resp/r_resp/r_data 0; wr_pulse 0.
  - Writable registers load RESET_VAL; AW/W holding registers emptied.
  - Any in-flight transaction is dropped with no response.
- Decode:
  - LSB = log2(DATA_WIDTH/8); idx = addr >> LSB; addr[LSB-1:0] ignored.
  - idx >= NUM_REGS gives DECERR (2'b11).
- Responses: OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11.
- Write path:
  - aw_ready = !aw_held && !b_valid; w_ready = !w_held && !b_valid (both combinational from registered state).
  - AW and W may complete in any order or in the same cycle; each is captured into its own holding register.
  - On the first edge where both are held:
    - Commit the write and set b_valid=1 with b_resp.
    - Clear both holds.
    - Pulse wr_pulse[idx] for exactly one cycle if the register was updated.
  - Latency: AW+W handshake on edge N gives b_valid=1 and the reg_q update after edge N+1.
  - Byte k of a writable register updates iff w_strb[k]=1. w_strb=0 gives OKAY, no data change, no wr_pulse.
  - Write to a RO register: no change, no wr_pulse, SLVERR.
  - Write to an out-of-range idx: no change, DECERR.
  - b_valid holds with a stable b_resp until b_ready. Clears on the b_ready edge; new AW/W are accepted from the next cycle.
- Read path:
  - ar_ready = !r_valid.
  - AR handshake on edge N gives r_valid=1 after edge N, with r_data/r_resp registered at edge N.
  - Writable register: read returns its reg_q value.
  - RO register: read returns reg_hw_in slice sampled at edge N, OKAY.
  - Out-of-range: r_data=0, DECERR.
  - r_valid, r_data and r_resp stay stable until r_ready. Back-to-back reads are allowed at one per two cycles.
- Simultaneous read and write:
  - Read and write channels are independent.
  - A read sampled on the same edge as a write commit to the same register returns the pre-write value.
- reg_q slices for RO registers are driven with 0.

Test Plan:
- Reset, then read idx 3 (addr 0x0C) -> r_valid one cycle after AR, r_data=RESET_VAL, r_resp=00.
- AW addr 0x08 in cycle 1, W data 0xDEADBEEF strb 0xF in cycle 4 -> b_valid cycle 5 with 00; reg_q[2]=0xDEADBEEF; wr_pulse[2] high one cycle; readback matches.
- reg 1 = 0x11223344, write 0xAABBCCDD strb 0b0101 -> reg 1 = 0x11BB33DD.
- RO_MASK=8'h10, reg_hw_in[4]=0x0000CAFE:
  - Write idx 4 -> SLVERR, no wr_pulse.
  - Read idx 4 -> 0x0000CAFE, OKAY.
- Access addr 0x20 with NUM_REGS=8:
  - Write -> DECERR, no register changes.
  - Read -> r_data=0, DECERR.
- Stall b_ready low for 5 cycles -> aw_ready/w_ready low and b_resp stable throughout. Assert rst_n=0 during a pending AW-only hold -> all outputs 0 next cycle, no b_valid after release.
